sr_cmd_gen: RTL and testbench

//  Upstream command stage for sr_ff. Turns two raw, asynchronous, bouncy request

---
 rtl/sr_cmd_gen.sv | 169 ++++++++++++++++
 tb/tb_sr_cmd_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_gen.sv
// Command stage for sr_ff: synchronises, debounces and edge-detects two raw request
// lines and emits registered, mutually exclusive S/R pulses with a forced idle gap.
module sr_cmd_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PULSE_LEN       = 2,
    parameter int unsigned GAP_CYCLES      = 3,
    parameter bit          PRIORITY_SET    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic set_in,
    input  logic reset_in,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict
);

    localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TMAX = (PULSE_LEN > GAP_CYCLES) ? PULSE_LEN : GAP_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GAP     = 2'd3
    } state_e;

    // Channel index 0 = set, 1 = reset throughout.
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    deb_q, deb_d, deb_prev_q;
    logic [1:0]    pend_q, pend_d, rise, take;
    logic          conflict_q, conflict_d;
    logic [TW-1:0] tmr_q, tmr_d, tmr_inc;
    state_e        state_q, state_d;
    logic          s_q, s_d, r_q, r_d, busy_q, busy_d;

    for (genvar g = 0; g < 2; g++) begin : g_deb
        logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
        logic          deb_nx;

        assign cnt_inc = cnt_q + CW'(1);

        // Count consecutive disagreeing cycles; accept the new level on the D-th one.
        always_comb begin
            cnt_d  = '0;
            deb_nx = deb_q[g];
            if (sync2_q[g] != deb_q[g]) begin
                if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
                    deb_nx = sync2_q[g];
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign deb_d[g] = deb_nx;
    end

    assign rise    = deb_q & ~deb_prev_q;
    assign pend_d  = (pend_q & ~take) | rise;
    assign tmr_inc = tmr_q + TW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            pend_q     <= '0;
            conflict_q <= 1'b0;
            tmr_q      <= '0;
        end else begin
            sync1_q    <= {reset_in, set_in};
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            pend_q     <= pend_d;
            conflict_q <= conflict_d;
            tmr_q      <= tmr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, pending consumption, conflict flag and phase timer.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        take       = 2'b00;
        conflict_d = conflict_q;
        unique case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (pend_q == 2'b11) begin
                    conflict_d = 1'b1;
                    take       = 2'b11;
                    state_d    = PRIORITY_SET ? PULSE_S : PULSE_R;
                end else if (pend_q[0]) begin
                    take    = 2'b01;
                    state_d = PULSE_S;
                end else if (pend_q[1]) begin
                    take    = 2'b10;
                    state_d = PULSE_R;
                end
            end
            PULSE_S, PULSE_R: begin
                if (tmr_inc == TW'(PULSE_LEN)) begin
                    tmr_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            GAP: begin
                if (tmr_inc == TW'(GAP_CYCLES)) begin
                    tmr_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the next state so the registered copies align with it.
    always_comb begin
        s_d    = 1'b0;
        r_d    = 1'b0;
        busy_d = 1'b0;
        s_d    = (state_d == PULSE_S);
        r_d    = (state_d == PULSE_R);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= 1'b0;
            r_q    <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            r_q    <= r_d;
            busy_q <= busy_d;
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: directed scenarios with literal expectations plus a long
// randomized run, all compared each cycle against a timestamp-based model.
module tb_sr_cmd_gen;

    localparam int D   = 4;
    localparam int PL  = 2;
    localparam int GAP = 3;

    logic clk = 1'b0;
    logic rst, set_in, reset_in;
    logic S, R, busy, conflict;

    always #5 clk = ~clk;

    sr_cmd_gen #(
        .DEBOUNCE_CYCLES(D),
        .PULSE_LEN      (PL),
        .GAP_CYCLES     (GAP),
        .PRIORITY_SET   (1'b0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .set_in  (set_in),
        .reset_in(reset_in),
        .S       (S),
        .R       (R),
        .busy    (busy),
        .conflict(conflict)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: pipeline bits per channel, and a pulse described by its start edge.
    logic m_s1[2], m_s2[2], m_deb[2], m_debp[2], m_pend[2];
    int   m_run[2];
    logic m_conf;
    int   m_edge   = 0;
    bit   m_active = 0;
    int   m_start  = 0;
    int   m_ch     = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_edge(input logic rs, input logic in0, input logic in1);
        logic rise[2];
        logic take[2];
        logic ins[2];
        bit   idle;
        m_edge++;
        ins[0] = in0;
        ins[1] = in1;
        if (rs) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_debp[i] = 0;
                m_pend[i] = 0; m_run[i] = 0;
            end
            m_conf   = 0;
            m_active = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rise[i] = m_deb[i] & ~m_debp[i];
                take[i] = 0;
            end
            idle = !m_active || ((m_edge - 1 - m_start) >= PL + GAP);
            if (idle && (m_pend[0] || m_pend[1])) begin
                if (m_pend[0] && m_pend[1]) begin
                    m_conf = 1;
                    take[0] = 1;
                    take[1] = 1;
                    m_ch = 1;
                end else begin
                    m_ch = m_pend[0] ? 0 : 1;
                    take[m_ch] = 1;
                end
                m_active = 1;
                m_start  = m_edge;
            end
            for (int i = 0; i < 2; i++) begin
                m_pend[i] = (m_pend[i] & ~take[i]) | rise[i];
                m_debp[i] = m_deb[i];
                if (m_s2[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_deb[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = ins[i];
            end
        end
    endtask

    // One clock: drive, clock edge, advance model, compare away from the edge.
    task automatic tick(input logic rs, input logic s, input logic r);
        int k;
        rst      = rs;
        set_in   = s;
        reset_in = r;
        @(posedge clk);
        model_edge(rs, s, r);
        #1;
        k = m_edge - m_start;
        check("S",        S,        logic'(m_active && m_ch == 0 && k < PL));
        check("R",        R,        logic'(m_active && m_ch == 1 && k < PL));
        check("busy",     busy,     logic'(m_active && k < PL + GAP));
        check("conflict", conflict, m_conf);
        check("S_and_R",  S & R,    1'b0);
    endtask

    initial begin
        int cnt_s, cnt_r, cnt_b, first;
        logic rs_v, s_v, r_v;
        int mode;

        // Reset with random inputs: all outputs held low.
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check("rst_S", S, 1'b0);
            check("rst_R", R, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_conflict", conflict, 1'b0);
        end
        tick(1'b0, 1'b0, 1'b0);

        // Clean set press: S after edges 8 and 9, busy for 5 cycles.
        cnt_b = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(1'b0, 1'b1, 1'b0);
            check("sc2_S_lit", S, logic'(k == 8 || k == 9));
            check("sc2_R_lit", R, 1'b0);
            if (busy) cnt_b++;
        end
        check_int("sc2_busy_len", cnt_b, 5);
        check("sc2_conflict_lit", conflict, 1'b0);

        // Short bounce: never qualifies.
        tick(1'b1, 1'b0, 1'b0);
        cnt_s = 0;
        for (int k = 1; k <= 18; k++) begin
            tick(1'b0, logic'(k <= 3), 1'b0);
            if (S || busy) cnt_s++;
        end
        check_int("sc3_no_pulse", cnt_s, 0);
        check("sc3_deb_level", dut.deb_q[0], 1'b0);

        // Simultaneous press: reset wins, one 2-cycle R pulse, sticky conflict.
        tick(1'b1, 1'b0, 1'b0);
        cnt_s = 0;
        cnt_r = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(1'b0, 1'b1, 1'b1);
            if (S) cnt_s++;
            if (R) cnt_r++;
        end
        check_int("sc4_S_count", cnt_s, 0);
        check_int("sc4_R_count", cnt_r, 2);
        check("sc4_conflict_lit", conflict, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        check("sc4_conflict_cleared", conflict, 1'b0);

        // Reset request whose edge lands in the gap: R served right after the gap.
        first = 0;
        cnt_s = 0;
        for (int k = 1; k <= 24; k++) begin
            tick(1'b0, 1'b1, logic'(k >= 5));
            if (R && first == 0) first = k;
            if (S) cnt_s++;
        end
        check_int("sc5_R_first", first, 14);
        check_int("sc5_S_count", cnt_s, 2);

        // Reset mid-pulse with set held, then re-qualification.
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) tick(1'b0, 1'b1, 1'b0);
        check("sc6_S_before", S, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        check("sc6_S_dropped", S, 1'b0);
        first = 0;
        cnt_s = 0;
        for (int k = 1; k <= 14; k++) begin
            tick(1'b0, 1'b1, 1'b0);
            if (S && first == 0) first = k;
            if (S) cnt_s++;
        end
        check_int("sc6_S_first", first, D + 4);
        check_int("sc6_S_count", cnt_s, PL);

        // Randomized run alternating bouncy and calm input phases.
        s_v = 0;
        r_v = 0;
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 60 == 0) mode = int'($urandom_range(0, 2));
            rs_v = logic'($urandom_range(0, 399) == 0);
            if (mode == 0) begin
                if ($urandom_range(0, 3) == 0) s_v = ~s_v;
                if ($urandom_range(0, 3) == 0) r_v = ~r_v;
            end else begin
                if ($urandom_range(0, 29) == 0) s_v = ~s_v;
                if ($urandom_range(0, 29) == 0) r_v = ~r_v;
            end
            tick(rs_v, s_v, r_v);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
